// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative restoring divider.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_TAG_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  typedef struct packed {
    logic                 is_unsigned;
    logic [DIV_WIDTH-1:0] dividend;
    logic [DIV_WIDTH-1:0] divisor;
    logic [DIV_TAG_W-1:0] tag;
  } div_req_t;

  // Number of CALC cycles needed to retire all quotient bits.
  function automatic int unsigned div_iters(input int unsigned width, input int unsigned steps);
    return width / steps;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step on the {remainder, dividend/quotient} pair.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH-1:0] rem_out
);

  logic [WIDTH:0] trial_hi;
  logic           fits;

  // Shifted partial remainder; one extra bit because 2R+1 can exceed WIDTH bits.
  assign trial_hi = rem_in[2*WIDTH-1:WIDTH-1];
  assign fits     = trial_hi >= {1'b0, divisor};
  assign rem_out  = {fits ? WIDTH'(trial_hi - {1'b0, divisor}) : trial_hi[WIDTH-1:0],
                     rem_in[WIDTH-2:0], fits};

endmodule

// File: rtl/div_unit.sv
// Parametrised iterative restoring divider with valid/ready handshakes and flush.
// Optional DIV_EARLY_OUT_EN: finish in one cycle when |dividend| < |divisor|.
module div_unit
  import div_pkg::*;
#(
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned STEPS_PER_CYCLE = 1,
  parameter int unsigned TAG_W           = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_unsigned,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned N     = div_iters(WIDTH, STEPS_PER_CYCLE);
  localparam int unsigned CNT_W = $clog2(N + 1);
  localparam int unsigned ACC_W = 2 * WIDTH;

  div_state_e       state, next_state;
  logic             in_ready_d, out_valid_d;
  logic [ACC_W-1:0] acc;
  logic [WIDTH-1:0] div_mag;
  logic             neg_q, neg_r;
  logic [CNT_W-1:0] cnt;

  logic             accept, is_signed, a_neg, b_neg, div_zero, sgn_ovf, special;
  logic [WIDTH-1:0] a_mag, b_mag, spec_q, spec_r, res_q, res_r;
  logic [ACC_W-1:0] chain [STEPS_PER_CYCLE+1];

  assign accept    = (state == IDLE) && in_valid && !flush;
  assign is_signed = !in_unsigned;
  assign a_neg     = is_signed && in_dividend[WIDTH-1];
  assign b_neg     = is_signed && in_divisor[WIDTH-1];
  assign a_mag     = a_neg ? -in_dividend : in_dividend;
  assign b_mag     = b_neg ? -in_divisor : in_divisor;
  assign div_zero  = (in_divisor == '0);
  assign sgn_ovf   = is_signed && (in_dividend == {1'b1, {(WIDTH-1){1'b0}}})
                     && (in_divisor == '1);

`ifdef DIV_EARLY_OUT_EN
  assign special = div_zero || sgn_ovf || (a_mag < b_mag);
`else
  assign special = div_zero || sgn_ovf;
`endif

  // Results for operands resolved at accept; the fallthrough covers early-out.
  always_comb begin
    spec_q = '0;
    spec_r = in_dividend;
    if (div_zero) begin
      spec_q = '1;
    end else if (sgn_ovf) begin
      spec_q = in_dividend;
      spec_r = '0;
    end
  end

  assign chain[0] = acc;
  for (genvar i = 0; i < STEPS_PER_CYCLE; i++) begin : g_step
    div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (chain[i]),
      .divisor (div_mag),
      .rem_out (chain[i+1])
    );
  end

  assign res_q = acc[WIDTH-1:0];
  assign res_r = acc[ACC_W-1:WIDTH];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= next_state;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
    end
  end

  always_comb begin
    next_state = state;
    if (flush) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (in_valid) next_state = special ? DONE : CALC;
        CALC:    if (cnt == CNT_W'(1)) next_state = FIX;
        FIX:     next_state = DONE;
        DONE:    if (out_ready) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Handshake flags are registered copies of the next-state decode.
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    if (next_state == IDLE) in_ready_d = 1'b1;
    if (next_state == DONE) out_valid_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc           <= '0;
      div_mag       <= '0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      cnt           <= '0;
      out_quotient  <= '0;
      out_remainder <= '0;
      out_tag       <= '0;
    end else if (accept) begin
      acc     <= {{WIDTH{1'b0}}, a_mag};
      div_mag <= b_mag;
      neg_q   <= a_neg ^ b_neg;
      neg_r   <= a_neg;
      cnt     <= CNT_W'(N);
      out_tag <= in_tag;
      if (special) begin
        out_quotient  <= spec_q;
        out_remainder <= spec_r;
      end
    end else if (state == CALC) begin
      acc <= chain[STEPS_PER_CYCLE];
      cnt <= cnt - CNT_W'(1);
    end else if (state == FIX) begin
      out_quotient  <= neg_q ? -res_q : res_q;
      out_remainder <= neg_r ? -res_r : res_r;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: a 32-bit radix-2 instance and a 16-bit 4-steps-per-cycle instance.
module tb_div_unit;
  import div_pkg::*;

`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    logic [4:0]  tag;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, flush;
  logic        iv32, ir32, iu32, ov32, or32;
  logic [31:0] a32, b32, q32, r32;
  logic [4:0]  it32, ot32;
  logic        iv16, ir16, iu16, ov16, or16;
  logic [15:0] a16, b16, q16, r16;
  logic [4:0]  it16, ot16;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp32[$];
  exp_t exp16[$];

  div_unit #(.WIDTH(32), .STEPS_PER_CYCLE(1), .TAG_W(5)) dut32 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(iv32), .in_ready(ir32), .in_unsigned(iu32),
    .in_dividend(a32), .in_divisor(b32), .in_tag(it32),
    .out_valid(ov32), .out_ready(or32),
    .out_quotient(q32), .out_remainder(r32), .out_tag(ot32)
  );

  div_unit #(.WIDTH(16), .STEPS_PER_CYCLE(4), .TAG_W(5)) dut16 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(iv16), .in_ready(ir16), .in_unsigned(iu16),
    .in_dividend(a16), .in_divisor(b16), .in_tag(it16),
    .out_valid(ov16), .out_ready(or16),
    .out_quotient(q16), .out_remainder(r16), .out_tag(ot16)
  );

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endfunction

  // Reference model: plain integer arithmetic on w-bit operands.
  function automatic logic [63:0] mask_of(input int unsigned w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic longint sext(input int unsigned w, input logic [63:0] x);
    longint v;
    v = longint'(x << (64 - w));
    return v >>> (64 - w);
  endfunction

  function automatic logic [63:0] mag(input int unsigned w, input logic u, input logic [63:0] x);
    longint v;
    if (u) return x & mask_of(w);
    v = sext(w, x & mask_of(w));
    return (v < 0) ? 64'(-v) : 64'(v);
  endfunction

  task automatic model(input int unsigned w, input logic u, input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] q, output logic [63:0] r);
    logic [63:0] m, ua, ub;
    longint      sa, sb;
    m  = mask_of(w);
    ua = a & m;
    ub = b & m;
    if (ub == 0) begin
      q = m;
      r = ua;
    end else if (u) begin
      q = ua / ub;
      r = ua % ub;
    end else begin
      sa = sext(w, ua);
      sb = sext(w, ub);
      q  = 64'(sa / sb) & m;
      r  = 64'(sa % sb) & m;
    end
  endtask

  function automatic int exp_lat(input int unsigned w, input logic u, input logic [63:0] a,
                                 input logic [63:0] b, input int n);
    logic [63:0] m;
    m = mask_of(w);
    if ((b & m) == 0) return 1;
    if (!u && ((a & m) == (64'd1 << (w - 1))) && ((b & m) == m)) return 1;
    if (EARLY && (mag(w, u, a) < mag(w, u, b))) return 1;
    return n + 2;
  endfunction

  // Compare process: every cycle a result is presented it must match the head of the model queue.
  always @(negedge clk) begin
    if (reset_n) begin
      if (exp32.size() == 0) begin
        check("idle_valid32", 64'(ov32), 64'd0);
      end else if (ov32) begin
        check("cmp32_q", 64'(q32), exp32[0].q);
        check("cmp32_r", 64'(r32), exp32[0].r);
        check("cmp32_tag", 64'(ot32), 64'(exp32[0].tag));
        if (or32) void'(exp32.pop_front());
      end
      if (exp16.size() == 0) begin
        check("idle_valid16", 64'(ov16), 64'd0);
      end else if (ov16) begin
        check("cmp16_q", 64'(q16), exp16[0].q);
        check("cmp16_r", 64'(r16), exp16[0].r);
        check("cmp16_tag", 64'(ot16), 64'(exp16[0].tag));
        if (or16) void'(exp16.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send32(input div_req_t req);
    exp_t        e;
    logic [63:0] q, r;
    int          guard;
    guard = 0;
    while (!ir32 && guard < 100) begin
      tick();
      guard++;
    end
    check("send32_in_ready", 64'(ir32), 64'd1);
    iv32 = 1'b1; iu32 = req.is_unsigned; a32 = req.dividend; b32 = req.divisor; it32 = req.tag;
    model(32, req.is_unsigned, 64'(req.dividend), 64'(req.divisor), q, r);
    e.q = q; e.r = r; e.tag = req.tag;
    exp32.push_back(e);
    tick();
    iv32 = 1'b0; iu32 = ~iu32; a32 = $urandom; b32 = $urandom; it32 = 5'($urandom);
  endtask

  task automatic wait_valid32(output int lat);
    lat = 1;
    while (!ov32 && lat < 100) begin
      tick();
      lat++;
    end
    if (!ov32) check("timeout32", 64'(ov32), 64'd1);
  endtask

  task automatic op32(input div_req_t req, input string name, input logic [31:0] q_lit,
                      input logic [31:0] r_lit, input int lat_lit);
    int          lat;
    logic [63:0] mq, mr;
    or32 = 1'b1;
    send32(req);
    wait_valid32(lat);
    check({name, "_lat"}, 64'(lat), 64'(lat_lit));
    check({name, "_q"}, 64'(q32), 64'(q_lit));
    check({name, "_r"}, 64'(r32), 64'(r_lit));
    check({name, "_tag"}, 64'(ot32), 64'(req.tag));
    model(32, req.is_unsigned, 64'(req.dividend), 64'(req.divisor), mq, mr);
    check({name, "_model_q"}, mq, 64'(q_lit));
    check({name, "_model_r"}, mr, 64'(r_lit));
    tick();
    check({name, "_ready_after"}, 64'(ir32), 64'd1);
    check({name, "_valid_after"}, 64'(ov32), 64'd0);
  endtask

  task automatic run32(input div_req_t req);
    int lat;
    or32 = 1'b1;
    send32(req);
    wait_valid32(lat);
    check("rand32_lat", 64'(lat),
          64'(exp_lat(32, req.is_unsigned, 64'(req.dividend), 64'(req.divisor), 32)));
    tick();
  endtask

  task automatic run16(input logic u, input logic [15:0] a, input logic [15:0] b, input logic [4:0] tag,
                       output int lat);
    exp_t        e;
    logic [63:0] q, r;
    int          guard;
    guard = 0;
    or16 = 1'b1;
    while (!ir16 && guard < 100) begin
      tick();
      guard++;
    end
    check("send16_in_ready", 64'(ir16), 64'd1);
    iv16 = 1'b1; iu16 = u; a16 = a; b16 = b; it16 = tag;
    model(16, u, 64'(a), 64'(b), q, r);
    e.q = q; e.r = r; e.tag = tag;
    exp16.push_back(e);
    tick();
    iv16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
    lat = 1;
    while (!ov16 && lat < 100) begin
      tick();
      lat++;
    end
    if (!ov16) check("timeout16", 64'(ov16), 64'd1);
    check("run16_lat", 64'(lat), 64'(exp_lat(16, u, 64'(a), 64'(b), 4)));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    div_req_t    req;
    int          lat;
    logic [31:0] hq, hr;
    logic [4:0]  ht;
    logic [15:0] ea [6];
    logic [15:0] sa, sb;
    ea = '{16'h8000, 16'hFFFF, 16'h0000, 16'h7FFF, 16'h0001, 16'h0003};

    reset_n = 1'b0; flush = 1'b0;
    iv32 = 1'b0; iu32 = 1'b0; a32 = '0; b32 = '0; it32 = '0; or32 = 1'b1;
    iv16 = 1'b0; iu16 = 1'b0; a16 = '0; b16 = '0; it16 = '0; or16 = 1'b1;
    repeat (3) tick();
    check("rst_in_ready32", 64'(ir32), 64'd1);
    check("rst_out_valid32", 64'(ov32), 64'd0);
    check("rst_q32", 64'(q32), 64'd0);
    check("rst_r32", 64'(r32), 64'd0);
    check("rst_tag32", 64'(ot32), 64'd0);
    check("rst_in_ready16", 64'(ir16), 64'd1);
    check("rst_out_valid16", 64'(ov16), 64'd0);
    reset_n = 1'b1;
    tick();

    op32('{1'b0, 32'hFFFFFFF9, 32'd2, 5'd5}, "s_m7_div_2", 32'hFFFFFFFD, 32'hFFFFFFFF, 34);
    op32('{1'b1, 32'hFFFFFFFF, 32'h10, 5'd9}, "u_max_div_16", 32'h0FFFFFFF, 32'hF, 34);
    op32('{1'b0, 32'hFFFFFFFF, 32'h10, 5'd10}, "s_m1_div_16", 32'h0, 32'hFFFFFFFF, EARLY ? 1 : 34);
    op32('{1'b1, 32'd5, 32'd0, 5'd11}, "u_div_zero", 32'hFFFFFFFF, 32'd5, 1);
    op32('{1'b0, 32'h80000000, 32'hFFFFFFFF, 5'd12}, "s_overflow", 32'h80000000, 32'd0, 1);
    op32('{1'b0, 32'hFFFFFFEC, 32'd0, 5'd13}, "s_div_zero", 32'hFFFFFFFF, 32'hFFFFFFEC, 1);

    // Backpressure: result held stable while the consumer stalls.
    or32 = 1'b0;
    send32('{1'b1, 32'd1000, 32'd3, 5'd21});
    wait_valid32(lat);
    check("bp_lat", 64'(lat), 64'd34);
    hq = q32; hr = r32; ht = ot32;
    check("bp_q", 64'(hq), 64'd333);
    check("bp_r", 64'(hr), 64'd1);
    repeat (10) begin
      tick();
      check("bp_valid_held", 64'(ov32), 64'd1);
      check("bp_in_ready_low", 64'(ir32), 64'd0);
      check("bp_q_stable", 64'(q32), 64'(hq));
      check("bp_r_stable", 64'(r32), 64'(hr));
      check("bp_tag_stable", 64'(ot32), 64'(ht));
    end
    or32 = 1'b1;
    tick();
    check("bp_release_in_ready", 64'(ir32), 64'd1);
    check("bp_release_valid", 64'(ov32), 64'd0);

    // Flush during CALC: the operation and a concurrent request are dropped.
    send32('{1'b1, 32'd12345, 32'd67, 5'd3});
    repeat (11) tick();
    flush = 1'b1; iv32 = 1'b1; iu32 = 1'b1; a32 = 32'd5; b32 = 32'd0;
    tick();
    flush = 1'b0; iv32 = 1'b0;
    void'(exp32.pop_back());
    check("flush_calc_in_ready", 64'(ir32), 64'd1);
    check("flush_calc_valid", 64'(ov32), 64'd0);
    lat = 0;
    repeat (40) begin
      tick();
      if (ov32) lat++;
    end
    check("flush_calc_no_valid", 64'(lat), 64'd0);
    op32('{1'b1, 32'd100, 32'd7, 5'd4}, "after_flush", 32'd14, 32'd2, 34);

    // Flush in IDLE blocks a request that would otherwise complete in one cycle.
    flush = 1'b1; iv32 = 1'b1; iu32 = 1'b1; a32 = 32'd9; b32 = 32'd0;
    tick();
    flush = 1'b0; iv32 = 1'b0;
    check("flush_idle_valid", 64'(ov32), 64'd0);
    check("flush_idle_in_ready", 64'(ir32), 64'd1);

    // Flush in DONE drops a stalled result.
    or32 = 1'b0;
    send32('{1'b1, 32'd9, 32'd0, 5'd7});
    wait_valid32(lat);
    check("flush_done_lat", 64'(lat), 64'd1);
    repeat (2) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    void'(exp32.pop_front());
    check("flush_done_valid", 64'(ov32), 64'd0);
    check("flush_done_in_ready", 64'(ir32), 64'd1);
    or32 = 1'b1;

    for (int k = 0; k < 12; k++) begin
      req.is_unsigned = k[0];
      req.dividend    = (k == 3) ? 32'h80000000 : $urandom;
      req.divisor     = (k == 5) ? 32'd0 : ((k % 3 == 0) ? 32'($urandom_range(1, 100)) : $urandom);
      req.tag         = 5'(k);
      run32(req);
    end

    // 16-bit, four quotient bits per cycle.
    run16(1'b1, 16'hFFFF, 16'd3, 5'd17, lat);
    check("w16_lat_lit", 64'(lat), 64'd6);
    check("w16_q_lit", 64'(q16), 64'h5555);
    check("w16_r_lit", 64'(r16), 64'h0);
    tick();
    for (int k = 0; k < 48; k++) begin
      sa = (k % 4 == 0) ? ea[$urandom_range(0, 5)] : 16'($urandom);
      sb = (k % 3 == 0) ? ea[$urandom_range(0, 5)]
                        : ((k % 3 == 1) ? 16'($urandom_range(1, 40)) : 16'($urandom));
      if (k == 7) begin
        sa = 16'h8000;
        sb = 16'hFFFF;
      end
      run16(k % 5 == 4, sa, sb, 5'(k), lat);
      tick();
    end

    repeat (3) tick();
    check("queue32_drained", 64'(exp32.size()), 64'd0);
    check("queue16_drained", 64'(exp16.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
